kmeans_seq_ctrl: RTL and testbench
==================================

KMEANS_SEQ_CTRL -- requirements
Module: kmeans_seq_ctrl

Interface
REQ-001 SHALL have parameter addrWidth, default 8, APB/register-file address width.
REQ-002 SHALL have parameter dataWidth, default 91, APB/register-file data width.
REQ-003 SHALL have parameter iterWidth, default 8, iteration counter width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-005 SHALL have APB slave inputs: paddr in addrWidth; pwrite in 1; psel in 1; penable in 1; pwdata in dataWidth.
REQ-006 SHALL have APB slave outputs: prdata out dataWidth, read data; pready out 1, transfer complete.
REQ-007 SHALL have register-file ports: rf_we out 1; rf_addr out addrWidth; rf_wdata out dataWidth; rf_rdata in dataWidth, valid one cycle after rf_addr.
REQ-008 SHALL have core ports: core_start out 1, one-cycle pulse starting one iteration; core_abort out 1, one-cycle pulse; core_iter_done in 1, one-cycle pulse; core_converged in 1, sampled with core_iter_done.
REQ-009 SHALL have irq out 1, level, set on DONE entry.

Function
REQ-010 SHALL decode local registers: 0x00 CTRL (W: bit0 start, bit1 abort, bit2 irq_clear); 0x01 STATUS (RO: [1:0] state, [2] converged, [3] done, [4+iterWidth-1:4] iter_cnt); 0x02 MAX_ITER (RW, iterWidth bits, reset 1).
REQ-011 SHALL forward addresses 0x10-0xFF to the register file; 0x03-0x0F read 0, writes ignored.
REQ-012 SHALL complete local-register accesses with pready=1 in the first access-phase cycle (psel&penable), zero wait states.
REQ-013 SHALL complete forwarded writes in the first access cycle with rf_we=1 for exactly that cycle, rf_addr=paddr, rf_wdata=pwdata, when state is IDLE or DONE.
REQ-014 SHALL complete forwarded reads with one wait state: rf_addr=paddr in first access cycle, pready=1 and prdata=rf_rdata in the second.
REQ-015 SHALL hold pready=0 for forwarded accesses while state is RUN or CHECK, completing them per REQ-013/014 once state leaves RUN/CHECK.
REQ-016 SHALL drive prdata=0 whenever pready=0 or the transfer is a write.
REQ-017 SHALL implement FSM states IDLE(0), RUN(1), CHECK(2), DONE(3).
REQ-018 IDLE/DONE: CTRL write with bit0=1 -> RUN, iter_cnt cleared to 0, done and converged cleared, core_start pulsed on the transition cycle.
REQ-019 RUN: core_iter_done=1 -> CHECK, iter_cnt increments, converged latched from core_converged.
REQ-020 CHECK (one cycle): converged=1 or iter_cnt==MAX_ITER -> DONE; else -> RUN with core_start pulsed.
REQ-021 DONE: done=1, irq=1 until CTRL bit2 written or a new start.
REQ-022 CTRL bit1 write in RUN or CHECK SHALL pulse core_abort, go to IDLE next cycle, keep iter_cnt, leave done=0; abort takes priority over simultaneous start.
REQ-023 Start write while in RUN/CHECK SHALL be ignored.
REQ-024 MAX_ITER=0 SHALL be treated as 1; MAX_ITER writes during RUN/CHECK take effect at the next CHECK.
REQ-025 iter_cnt SHALL saturate at all-ones, never wrap.
REQ-026 core_iter_done outside RUN SHALL be ignored.

Reset
REQ-027 On rst: state=IDLE, iter_cnt=0, MAX_ITER=1, converged=0, done=0, irq=0, prdata=0, pready=0, rf_we=0, rf_addr=0, rf_wdata=0, core_start=0, core_abort=0.
REQ-028 Reset mid-transfer or mid-RUN SHALL discard the transfer and emit no core_abort pulse.

Structure
REQ-029 SHALL place local register addresses, STATUS bit positions and the state enum in shared package kmeans_pkg.
REQ-030 SHALL contain one sub-module, kmeans_apb_if (APB phase decode, wait-state generation); FSM in top.

Verification
REQ-031 Write 0x10<-0x1, read 0x10 in IDLE -> rf_we one cycle, read pready on 2nd access cycle, prdata=0x1.
REQ-032 MAX_ITER=3, start, core_converged=0 each iteration -> 3 core_start pulses, DONE, STATUS iter_cnt=3, irq=1.
REQ-033 MAX_ITER=5, converged=1 on 2nd iter_done -> DONE after 2 iterations, STATUS converged=1.
REQ-034 Forwarded read of 0x20 issued during RUN -> pready held 0 until DONE, then completes with rf_rdata.
REQ-035 Abort and start in same CTRL write during RUN -> one core_abort pulse, IDLE, no core_start.
REQ-036 rst asserted mid-RUN -> all outputs at reset values immediately, state IDLE, no core pulses.

Source files
------------

// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared register map, STATUS layout and FSM state encoding
package kmeans_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned REG_CTRL     = 'h00;
  localparam int unsigned REG_STATUS   = 'h01;
  localparam int unsigned REG_MAX_ITER = 'h02;
  localparam int unsigned RF_BASE      = 'h10;

  localparam int unsigned CTRL_START_BIT   = 0;
  localparam int unsigned CTRL_ABORT_BIT   = 1;
  localparam int unsigned CTRL_IRQ_CLR_BIT = 2;

  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_CONV_BIT  = 2;
  localparam int unsigned STAT_DONE_BIT  = 3;
  localparam int unsigned STAT_ITER_LSB  = 4;

  function automatic logic is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/kmeans_apb_if.sv
// rtl/kmeans_apb_if.sv - APB phase decode, local/forwarded split and wait-state generation
module kmeans_apb_if #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 91
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [addrWidth-1:0] paddr,
  input  logic                 pwrite,
  input  logic                 psel,
  input  logic                 penable,
  input  logic [dataWidth-1:0] pwdata,
  output logic [dataWidth-1:0] prdata,
  output logic                 pready,
  input  logic                 busy,
  input  logic [dataWidth-1:0] loc_rdata,
  output logic                 loc_we,
  output logic                 rf_we,
  output logic [addrWidth-1:0] rf_addr,
  output logic [dataWidth-1:0] rf_wdata,
  input  logic [dataWidth-1:0] rf_rdata
);
  import kmeans_pkg::*;

  logic access;
  logic fwd;
  logic rd_wait;

  assign access = psel & penable & ~rst;
  assign fwd    = (paddr >= addrWidth'(RF_BASE));

  // Marks that a forwarded read already presented its address; rf_rdata is valid next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_wait <= 1'b0;
    end else begin
      rd_wait <= access & fwd & ~pwrite & ~busy & ~rd_wait;
    end
  end

  assign pready   = access & (~fwd | (pwrite ? ~busy : rd_wait));
  assign loc_we   = access & ~fwd & pwrite;
  assign rf_we    = access & fwd & pwrite & ~busy;
  assign rf_addr  = (psel & fwd & ~rst) ? paddr : '0;
  assign rf_wdata = (psel & fwd & pwrite & ~rst) ? pwdata : '0;
  assign prdata   = (pready & ~pwrite) ? (fwd ? rf_rdata : loc_rdata) : '0;

endmodule

// File: rtl/kmeans_seq_ctrl.sv
// rtl/kmeans_seq_ctrl.sv - k-means iteration sequencer with APB registers and register-file bridge
module kmeans_seq_ctrl #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 91,
  parameter int iterWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [addrWidth-1:0] paddr,
  input  logic                 pwrite,
  input  logic                 psel,
  input  logic                 penable,
  input  logic [dataWidth-1:0] pwdata,
  output logic [dataWidth-1:0] prdata,
  output logic                 pready,
  output logic                 rf_we,
  output logic [addrWidth-1:0] rf_addr,
  output logic [dataWidth-1:0] rf_wdata,
  input  logic [dataWidth-1:0] rf_rdata,
  output logic                 core_start,
  output logic                 core_abort,
  input  logic                 core_iter_done,
  input  logic                 core_converged,
  output logic                 irq
);
  import kmeans_pkg::*;

  state_t               state, state_nx;
  logic [iterWidth-1:0] iter_cnt, max_iter, eff_max;
  logic                 converged, done;
  logic                 loc_we;
  logic [dataWidth-1:0] loc_rdata, status;
  logic                 ctrl_wr, max_wr, start_req, abort_req, irq_clr;
  logic                 do_start, do_count, do_done;
  logic                 unused_pwdata;

  kmeans_apb_if #(.addrWidth(addrWidth), .dataWidth(dataWidth)) u_apb_if (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .busy(is_busy(state)), .loc_rdata(loc_rdata), .loc_we(loc_we),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  assign ctrl_wr       = loc_we && (paddr == addrWidth'(REG_CTRL));
  assign max_wr        = loc_we && (paddr == addrWidth'(REG_MAX_ITER));
  assign start_req     = ctrl_wr && pwdata[CTRL_START_BIT];
  assign abort_req     = ctrl_wr && pwdata[CTRL_ABORT_BIT];
  assign irq_clr       = ctrl_wr && pwdata[CTRL_IRQ_CLR_BIT];
  assign eff_max       = (max_iter == '0) ? iterWidth'(1) : max_iter;
  assign unused_pwdata = ^pwdata;

  always_comb begin
    status = '0;
    status[STAT_STATE_LSB +: 2]         = state;
    status[STAT_CONV_BIT]               = converged;
    status[STAT_DONE_BIT]               = done;
    status[STAT_ITER_LSB +: iterWidth]  = iter_cnt;
    loc_rdata = '0;
    if (paddr == addrWidth'(REG_STATUS)) begin
      loc_rdata = status;
    end else if (paddr == addrWidth'(REG_MAX_ITER)) begin
      loc_rdata[iterWidth-1:0] = max_iter;
    end
  end

  // Abort is checked before start so a combined CTRL write in RUN/CHECK only aborts.
  always_comb begin
    state_nx   = state;
    core_start = 1'b0;
    core_abort = 1'b0;
    do_start   = 1'b0;
    do_count   = 1'b0;
    do_done    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_req) begin
          state_nx   = ST_RUN;
          core_start = 1'b1;
          do_start   = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_nx   = ST_IDLE;
          core_abort = 1'b1;
        end else if (core_iter_done) begin
          state_nx = ST_CHECK;
          do_count = 1'b1;
        end
      end
      ST_CHECK: begin
        if (abort_req) begin
          state_nx   = ST_IDLE;
          core_abort = 1'b1;
        end else if (converged || (iter_cnt >= eff_max)) begin
          state_nx = ST_DONE;
          do_done  = 1'b1;
        end else begin
          state_nx   = ST_RUN;
          core_start = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      iter_cnt  <= '0;
      max_iter  <= iterWidth'(1);
      converged <= 1'b0;
      done      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state <= state_nx;
      if (max_wr) max_iter <= pwdata[iterWidth-1:0];
      if (irq_clr) irq <= 1'b0;
      if (do_start) begin
        iter_cnt  <= '0;
        converged <= 1'b0;
        done      <= 1'b0;
        irq       <= 1'b0;
      end
      if (do_count) begin
        if (iter_cnt != '1) iter_cnt <= iter_cnt + 1'b1;
        converged <= core_converged;
      end
      if (do_done) begin
        done <= 1'b1;
        irq  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kmeans_seq_ctrl.sv
// tb/tb_kmeans_seq_ctrl.sv - randomized bench for kmeans_seq_ctrl against a behavioural model
module tb_kmeans_seq_ctrl;
  localparam int AW = 8;
  localparam int DW = 91;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic          pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata = '0;
  logic          core_start, core_abort;
  logic          core_iter_done = 1'b0, core_converged = 1'b0;
  logic          irq;

  int n_checks = 0;
  int n_fail = 0;

  kmeans_seq_ctrl #(.addrWidth(AW), .dataWidth(DW), .iterWidth(IW)) dut (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .core_start(core_start), .core_abort(core_abort),
    .core_iter_done(core_iter_done), .core_converged(core_converged), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file environment: one-cycle read latency.
  logic [DW-1:0] env_mem [256];
  initial begin
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] d;
    for (int i = 0; i < 256; i++) env_mem[i] = '0;
    forever begin
      @(negedge clk);
      a = rf_addr; w = rf_we; d = rf_wdata;
      @(posedge clk); #1;
      if (w) env_mem[a] = d;
      rf_rdata = env_mem[a];
    end
  end

  // Core environment: answers each core_start after a random delay.
  int dly_lo = 1, dly_hi = 4, conv_mode = 0, conv_n = 0, resp_cnt = 0, cd = 0;
  bit noise_en = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      core_iter_done = 1'b0;
      core_converged = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_iter_done = 1'b1;
          resp_cnt++;
          case (conv_mode)
            0:       core_converged = 1'b0;
            1:       core_converged = ($urandom_range(0, 3) == 0);
            default: core_converged = (resp_cnt == conv_n);
          endcase
        end
      end else if (noise_en && $urandom_range(0, 19) == 0) begin
        core_iter_done = 1'b1;
        core_converged = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (rst || core_abort) cd = 0;
      else if (core_start) cd = $urandom_range(dly_lo, dly_hi);
    end
  end

  int cnt_start = 0, cnt_abort = 0, cnt_we = 0;
  always @(negedge clk) begin
    if (core_start === 1'b1) cnt_start++;
    if (core_abort === 1'b1) cnt_abort++;
    if (rf_we === 1'b1) cnt_we++;
  end

  // Behavioural model: phase 0 idle, 1 running, 2 deciding, 3 finished (STATUS encoding).
  logic [DW-1:0] ref_mem [256];
  int m_phase = 0, m_iters = 0, m_max = 1, m_rd_seen = 0;
  bit m_conv = 0, m_done = 0, m_irq = 0;
  initial for (int i = 0; i < 256; i++) ref_mem[i] = '0;

  always @(negedge clk) begin : model
    bit access, fwd, busy, ctrl_wr, e_abort, e_start, e_iter, e_finish, e_restart, x_pready, x_we;
    logic [DW-1:0] x_prdata;
    int limit;
    if (rst) begin
      m_phase = 0; m_iters = 0; m_max = 1; m_conv = 0; m_done = 0; m_irq = 0; m_rd_seen = 0;
      chk("reset_outputs", {irq, pready, rf_we, core_start, core_abort, |prdata, |rf_addr, |rf_wdata}, 0);
    end else begin
      access   = psel && penable;
      fwd      = paddr >= 8'h10;
      busy     = (m_phase == 1) || (m_phase == 2);
      ctrl_wr  = access && pwrite && paddr == 0;
      limit    = (m_max == 0) ? 1 : m_max;
      e_abort  = busy && ctrl_wr && pwdata[1];
      e_start  = !busy && ctrl_wr && pwdata[0];
      e_iter   = m_phase == 1 && !e_abort && core_iter_done;
      e_finish = m_phase == 2 && !e_abort && (m_conv || m_iters >= limit);
      e_restart = m_phase == 2 && !e_abort && !e_finish;
      x_pready = 0; x_we = 0; x_prdata = '0;
      if (access) begin
        if (!fwd) x_pready = 1;
        else if (pwrite) begin x_pready = !busy; x_we = !busy; end
        else x_pready = !busy && m_rd_seen > 0;
      end
      if (x_pready && !pwrite) begin
        if (fwd) x_prdata = ref_mem[paddr];
        else if (paddr == 1) x_prdata = DW'(m_iters * 16 + m_done * 8 + m_conv * 4 + m_phase);
        else if (paddr == 2) x_prdata = DW'(m_max);
      end
      chk("pready", pready, x_pready);
      chk("prdata", prdata, x_prdata);
      chk("rf_we", rf_we, x_we);
      chk("core_start", core_start, e_start || e_restart);
      chk("core_abort", core_abort, e_abort);
      chk("irq", irq, m_irq);
      if (x_we) begin
        chk("rf_addr", rf_addr, paddr);
        chk("rf_wdata", rf_wdata, pwdata);
        ref_mem[paddr] = pwdata;
      end
      m_rd_seen = (access && fwd && !pwrite && !busy && !x_pready) ? 1 : 0;
      if (ctrl_wr && pwdata[2]) m_irq = 0;
      if (e_abort) m_phase = 0;
      else if (e_start) begin m_phase = 1; m_iters = 0; m_conv = 0; m_done = 0; m_irq = 0; end
      else if (e_iter) begin m_phase = 2; if (m_iters < 255) m_iters++; m_conv = core_converged; end
      else if (e_finish) begin m_phase = 3; m_done = 1; m_irq = 1; end
      else if (e_restart) m_phase = 1;
      if (access && pwrite && paddr == 2) m_max = int'(pwdata[IW-1:0]);
    end
  end

  task automatic apb(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] d,
                     output logic [DW-1:0] rd, output int ncyc);
    bit got;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; ncyc = 0; rd = '0; got = 0;
    while (!got && ncyc < 300) begin
      @(negedge clk);
      ncyc++;
      if (pready === 1'b1) begin got = 1; rd = prdata; end
    end
    chk("apb_complete", got, 1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] x;
    int n;
    apb(a, 1'b1, d, x, n);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
    int n;
    apb(a, 1'b0, '0, v, n);
  endtask

  task automatic wait_irq(input int bound);
    int n = 0;
    while (irq !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    chk("wait_irq", irq, 1);
  endtask

  initial begin
    logic [DW-1:0] v;
    int n;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    rd(8'h01, v); chk("reset_status", v, 0);
    rd(8'h02, v); chk("reset_max_iter", v, 1);
    chk("reset_irq", irq, 0);

    cnt_we = 0;
    apb(8'h10, 1'b1, DW'(1), v, n);
    chk("fwd_write_cycles", n, 1);
    chk("fwd_write_we_count", cnt_we, 1);
    apb(8'h10, 1'b0, '0, v, n);
    chk("fwd_read_cycles", n, 2);
    chk("fwd_read_data", v, 1);

    conv_mode = 0; dly_lo = 1; dly_hi = 4;
    wr(8'h02, DW'(3));
    cnt_start = 0;
    wr(8'h00, DW'(1));
    wait_irq(200);
    chk("maxiter3_starts", cnt_start, 3);
    rd(8'h01, v); chk("maxiter3_status", v, 'h3B);
    chk("maxiter3_irq", irq, 1);

    conv_mode = 2; conv_n = 2; resp_cnt = 0;
    wr(8'h02, DW'(5));
    cnt_start = 0;
    wr(8'h00, DW'(1));
    wait_irq(200);
    chk("converge_starts", cnt_start, 2);
    rd(8'h01, v); chk("converge_status", v, 'h2F);

    wr(8'h00, DW'(4));
    chk("irq_clear", irq, 0);
    rd(8'h01, v); chk("irq_clear_status", v, 'h2F);

    wr(8'h20, DW'('h5A5A));
    conv_mode = 0; dly_lo = 3; dly_hi = 6;
    wr(8'h02, DW'(2));
    wr(8'h00, DW'(1));
    apb(8'h20, 1'b0, '0, v, n);
    chk("busy_read_data", v, 'h5A5A);
    chk("busy_read_stalled", n > 2, 1);
    chk("busy_read_after_done", irq, 1);

    dly_lo = 30; dly_hi = 30;
    wr(8'h02, DW'(3));
    wr(8'h00, DW'(1));
    cnt_start = 0; cnt_abort = 0;
    wr(8'h00, DW'(3));
    repeat (10) @(posedge clk);
    chk("abort_pulses", cnt_abort, 1);
    chk("abort_no_start", cnt_start, 0);
    rd(8'h01, v); chk("abort_status", v, 0);

    dly_lo = 1; dly_hi = 2;
    wr(8'h02, DW'(0));
    wr(8'h00, DW'(1));
    wait_irq(100);
    rd(8'h01, v); chk("maxiter0_status", v, 'h1B);
    rd(8'h02, v); chk("maxiter0_readback", v, 0);

    wr(8'h05, DW'('hFF));
    rd(8'h05, v); chk("reserved_read", v, 0);

    dly_lo = 30; dly_hi = 30;
    wr(8'h02, DW'(3));
    wr(8'h00, DW'(1));
    repeat (3) @(posedge clk);
    cnt_start = 0; cnt_abort = 0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", {irq, pready, core_start, core_abort, rf_we}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    chk("midrun_reset_no_abort", cnt_abort, 0);
    chk("midrun_reset_no_start", cnt_start, 0);
    rd(8'h01, v); chk("midrun_reset_status", v, 0);
    rd(8'h02, v); chk("midrun_reset_max", v, 1);

    noise_en = 1; conv_mode = 1; dly_lo = 1; dly_hi = 5;
    for (int k = 0; k < 300; k++) begin
      int sel;
      logic [AW-1:0] a;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: wr(8'h00, DW'($urandom_range(0, 7)));
        2:    wr(8'h02, DW'($urandom_range(0, 4)));
        3:    rd(8'h01, v);
        4:    rd(8'h02, v);
        5, 6: wr(AW'($urandom_range(16, 255)), DW'({$urandom(), $urandom(), $urandom()}));
        7, 8: rd(AW'($urandom_range(16, 255)), v);
        default: begin
          a = AW'($urandom_range(3, 15));
          if ($urandom_range(0, 1) == 0) wr(a, DW'($urandom()));
          else rd(a, v);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (50) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
